// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-requester write-back arbiter.
// Holds the default index width, the registered entry layout and the source codes.
package wb_arb_pkg;

   localparam int RD_W_DEF = 5;

   localparam logic SRC_INT = 1'b0;
   localparam logic SRC_FP  = 1'b1;

   typedef struct packed {
      logic [31:0]         data;
      logic [RD_W_DEF-1:0] rd;
      logic                src;
   } wb_entry_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/mux_2X1_32bit.sv
// Shared 2:1 32-bit select component; i_sel = 0 picks i_a, i_sel = 1 picks i_b.
module mux_2X1_32bit (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_sel,
   output logic [31:0] o_y
);

   assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/wb_arb_2x1.sv
// Two-requester write-back arbiter feeding one register-file write port through a single entry.
// Round-robin between the integer ALU and FP unit; define WB_ARB_FIXED_PRIO_EN to always favour FP.
module wb_arb_2x1
   import wb_arb_pkg::*;
#(
   parameter int RD_W = RD_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [31:0]     req0_data,
   input  logic [RD_W-1:0] req0_rd,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [31:0]     req1_data,
   input  logic [RD_W-1:0] req1_rd,
   output logic            req1_ready,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [31:0]     wb_data,
   output logic [RD_W-1:0] wb_rd,
   output logic            wb_src
);

   // The entry layout is fixed by the package, so the index width must match it.
   if (RD_W != RD_W_DEF) begin : g_bad_rd_w
      $error("wb_arb_2x1: RD_W must equal wb_arb_pkg::RD_W_DEF");
   end

   wb_state_t       r_state;
   wb_state_t       w_state_nxt;
   wb_entry_t       r_entry;
   logic            w_load_en;
   logic            w_grant;
   logic            w_xfer;
   logic            w_keep;
   logic [31:0]     w_sel_data;
   logic [RD_W-1:0] w_sel_rd;
`ifndef WB_ARB_FIXED_PRIO_EN
   logic            r_last_grant;
`endif

   // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
   always_comb begin
      w_grant = SRC_INT;
      if (req0_valid && req1_valid)
`ifdef WB_ARB_FIXED_PRIO_EN
         w_grant = SRC_FP;
`else
         w_grant = ~r_last_grant;
`endif
      else if (req1_valid)
         w_grant = SRC_FP;
   end

   assign w_load_en  = !wb_valid | (wb_valid & wb_ready);
   assign req0_ready = !rst & w_load_en & req0_valid & (w_grant == SRC_INT);
   assign req1_ready = !rst & w_load_en & req1_valid & (w_grant == SRC_FP);
   assign w_xfer     = req0_ready | req1_ready;

   mux_2X1_32bit u_data_mux (
      .i_a   (req0_data),
      .i_b   (req1_data),
      .i_sel (w_grant),
      .o_y   (w_sel_data)
   );

   assign w_sel_rd = w_grant ? req1_rd : req0_rd;
   // Writes to index 0 are consumed from the requester but never reach the register file.
   assign w_keep   = w_xfer & (w_sel_rd != '0);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_load_en) w_state_nxt = w_keep ? ST_FULL : ST_EMPTY;
   end

   always_comb begin
      wb_valid = (r_state == ST_FULL);
   end

   // NOTE: the entry is cleared on reset so the write port sees defined data, not just a low valid.
   always_ff @(posedge clk) begin
      if (rst)         r_entry <= '0;
      else if (w_keep) r_entry <= '{data: w_sel_data, rd: w_sel_rd, src: w_grant};
   end

`ifndef WB_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk) begin
      if (rst)         r_last_grant <= SRC_FP;
      else if (w_xfer) r_last_grant <= w_grant;
   end
`endif

   assign wb_data = r_entry.data;
   assign wb_rd   = r_entry.rd;
   assign wb_src  = r_entry.src;

endmodule

// File: tb/tb_wb_arb_2x1.sv
// Self-checking bench for wb_arb_2x1: directed scenarios plus randomized traffic against a
// transaction-level model. Build with WB_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_wb_arb_2x1;

   localparam bit FIXED =
`ifdef WB_ARB_FIXED_PRIO_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_data, req1_data;
   logic [4:0]  req0_rd, req1_rd;
   logic        req0_ready, req1_ready;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_src;

   int n_pass  = 0;
   int n_total = 0;

   // Model state: what the write port should currently see, and who won last.
   bit        m_valid = 1'b0;
   bit [31:0] m_data  = '0;
   bit [4:0]  m_rd    = '0;
   bit        m_src   = 1'b0;
   bit        m_last  = 1'b1;

   wb_arb_2x1 dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_rd    (req0_rd),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_rd    (req1_rd),
      .req1_ready (req1_ready),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_data    (wb_data),
      .wb_rd      (wb_rd),
      .wb_src     (wb_src)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Which requester should win this cycle, or -1 if nobody asks.
   function automatic int m_winner();
      if (req0_valid && !req1_valid) return 0;
      if (req1_valid && !req0_valid) return 1;
      if (req0_valid && req1_valid)  return FIXED ? 1 : (m_last ? 0 : 1);
      return -1;
   endfunction

   function automatic logic m_ready(int x);
      return !rst && (!m_valid || wb_ready) && (m_winner() == x);
   endfunction

   // Advance the model by one accepted/drained cycle, then step the clock.
   task automatic tick();
      int       w;
      bit [4:0] rd;
      w = m_winner();
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_rd = '0; m_src = 1'b0; m_last = 1'b1;
      end else if (!m_valid || wb_ready) begin
         if (w >= 0) begin
            m_last = w[0];
            rd = (w == 1) ? req1_rd : req0_rd;
            if (rd != 0) begin
               m_valid = 1'b1;
               m_data  = (w == 1) ? req1_data : req0_data;
               m_rd    = rd;
               m_src   = w[0];
            end else begin
               m_valid = 1'b0;
            end
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] r0,
                        input logic v1, input logic [31:0] d1, input logic [4:0] r1,
                        input logic rdy);
      req0_valid = v0; req0_data = d0; req0_rd = r0;
      req1_valid = v1; req1_data = d1; req1_rd = r1;
      wb_ready   = rdy;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hAAAA_0000, 5'd1, 1'b1, 32'hBBBB_0000, 5'd2, 1'b1);
         n_total++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL reset_readies: got r0=%b r1=%b want 0/0", req0_ready, req1_ready);
         else n_pass++;
         tick();
      end
      n_total++;
      if (wb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", wb_valid);
      else n_pass++;
      n_total++;
      if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_src !== 1'b0)
         $display("FAIL reset_entry: got data=%h rd=%0d src=%b want 0/0/0", wb_data, wb_rd, wb_src);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_alternate();
      int g, prev_g;
      prev_g = 0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h2222_2222, 5'd4, 1'b1);
         g = FIXED ? 1 : k % 2;
         n_total++;
         if (req0_ready !== (g == 0) || req1_ready !== (g == 1))
            $display("FAIL alt_grant[%0d]: got r0=%b r1=%b want grant=%0d", k, req0_ready, req1_ready, g);
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (wb_valid !== 1'b1 || wb_data !== (prev_g == 1 ? 32'h2222_2222 : 32'h1111_1111))
               $display("FAIL alt_data[%0d]: got v=%b data=%h want source %0d", k, wb_valid, wb_data, prev_g);
            else n_pass++;
         end
         prev_g = g;
         tick();
      end
      n_total++;
      if (wb_data !== (prev_g == 1 ? 32'h2222_2222 : 32'h1111_1111) || wb_rd !== (prev_g == 1 ? 5'd4 : 5'd3))
         $display("FAIL alt_last: got data=%h rd=%0d want source %0d", wb_data, wb_rd, prev_g);
      else n_pass++;
   endtask

   task automatic test_stall();
      drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
      tick();
      drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b0, 32'h0, 5'd0, 1'b1);
      n_total++;
      if (req0_ready !== 1'b1) $display("FAIL stall_load: got r0=%b want 1", req0_ready);
      else n_pass++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h2222_2222, 5'd4, 1'b0);
         n_total++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL stall_readies[%0d]: got r0=%b r1=%b want 0/0", i, req0_ready, req1_ready);
         else n_pass++;
         n_total++;
         if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_rd !== 5'd7 || wb_src !== 1'b0)
            $display("FAIL stall_hold[%0d]: got v=%b data=%h rd=%0d src=%b want 1/deadbeef/7/0",
                     i, wb_valid, wb_data, wb_rd, wb_src);
         else n_pass++;
         tick();
      end
      drive(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h2222_2222, 5'd4, 1'b1);
      n_total++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
         $display("FAIL stall_release: got r0=%b r1=%b want 0/1", req0_ready, req1_ready);
      else n_pass++;
      tick();
      n_total++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h2222_2222 || wb_src !== 1'b1)
         $display("FAIL stall_next: got v=%b data=%h src=%b want 1/22222222/1", wb_valid, wb_data, wb_src);
      else n_pass++;
   endtask

   task automatic test_rd_zero();
      drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1);
      n_total++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
         $display("FAIL rd0_accept: got r0=%b r1=%b want 0/1", req0_ready, req1_ready);
      else n_pass++;
      tick();
      n_total++;
      if (wb_valid !== 1'b0) $display("FAIL rd0_discard: got wb_valid=%b want 0", wb_valid);
      else n_pass++;
      drive(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h2222_2222, 5'd4, 1'b1);
      n_total++;
      if (req0_ready !== !FIXED || req1_ready !== FIXED)
         $display("FAIL rd0_next_grant: got r0=%b r1=%b want %b/%b", req0_ready, req1_ready, !FIXED, FIXED);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      n_total++;
      if (wb_valid !== 1'b1) $display("FAIL midrst_full: got wb_valid=%b want 1", wb_valid);
      else n_pass++;
      rst = 1'b1;
      drive(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h2222_2222, 5'd4, 1'b1);
      n_total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
         $display("FAIL midrst_readies: got r0=%b r1=%b want 0/0", req0_ready, req1_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      n_total++;
      if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0)
         $display("FAIL midrst_clear: got v=%b data=%h rd=%0d want 0/0/0", wb_valid, wb_data, wb_rd);
      else n_pass++;
      drive(1'b1, 32'h1111_1111, 5'd3, 1'b1, 32'h2222_2222, 5'd4, 1'b1);
      n_total++;
      if (req0_ready !== !FIXED || req1_ready !== FIXED)
         $display("FAIL midrst_grant: got r0=%b r1=%b want %b/%b", req0_ready, req1_ready, !FIXED, FIXED);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic e0, e1;
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 60) == 0);
         drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0);
         e0 = m_ready(0);
         e1 = m_ready(1);
         n_total++;
         if (req0_ready !== e0 || req1_ready !== e1)
            $display("FAIL rand_ready[%0d]: got r0=%b r1=%b want %b/%b", i, req0_ready, req1_ready, e0, e1);
         else n_pass++;
         n_total++;
         if (wb_valid !== m_valid || wb_data !== m_data || wb_rd !== m_rd || wb_src !== m_src)
            $display("FAIL rand_out[%0d]: got v=%b d=%h rd=%0d s=%b want %b/%h/%0d/%b",
                     i, wb_valid, wb_data, wb_rd, wb_src, m_valid, m_data, m_rd, m_src);
         else n_pass++;
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_stall();
      test_rd_zero();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_arb_2x1.md
WB_ARB_2X1 -- requirements
Module: wb_arb_2x1

Interface
REQ-001 Parameter: RD_W, 5, width of the destination-register index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (integer ALU) has a result.
REQ-005 req0_data  input  32  requester 0 result.
REQ-006 req0_rd  input  RD_W  requester 0 destination index.
REQ-007 req0_ready  output  1  requester 0 result accepted this cycle.
REQ-008 req1_valid, req1_data, req1_rd, req1_ready: same as REQ-004..007 for requester 1 (FP unit).
REQ-009 wb_valid  output  1  write-back entry held.
REQ-010 wb_ready  input  1  register-file write port consumes entry.
REQ-011 wb_data  output  32  write-back data.
REQ-012 wb_rd  output  RD_W  write-back index.
REQ-013 wb_src  output  1  source of held entry (0 = req0, 1 = req1).

Function
REQ-014 The block SHALL hold one registered output entry (states EMPTY, FULL, tracked by wb_valid).
REQ-015 load_en SHALL equal (!wb_valid) | (wb_valid & wb_ready).
REQ-016 Grant SHALL go to the sole valid requester; when both are valid, to the requester not in last_grant.
REQ-017 reqX_ready SHALL equal load_en & reqX_valid & (grant == X), combinationally; at most one ready high per cycle.
REQ-018 On a transfer (reqX_valid & reqX_ready), data/rd/src SHALL be registered and wb_valid set the next cycle; latency is 1 cycle.
REQ-019 last_grant SHALL update only on a transfer, never on a mere valid.
REQ-020 A transfer with rd == 0 SHALL be accepted (ready asserted) but discarded: wb_valid is not set by it, last_grant still updates.
REQ-021 While wb_valid & !wb_ready, wb_data/wb_rd/wb_src SHALL stay stable and both readies stay low.
REQ-022 wb_ready & wb_valid with no incoming transfer SHALL move to EMPTY (wb_valid = 0) next cycle; data/rd/src retain their last values.
REQ-023 Simultaneous drain and load SHALL replace the entry back-to-back, sustaining one write per cycle.
REQ-024 wb_ready while EMPTY SHALL have no effect.
REQ-025 Data steering into the output register SHALL be a 2:1 32-bit select whose sel is the grant.

Reset
REQ-026 While rst is high at a clock edge: wb_valid = 0, wb_data = 0, wb_rd = 0, wb_src = 0, last_grant = 1 (req0 wins first contention).
REQ-027 Reset mid-operation SHALL discard any held entry.
REQ-028 Both readies SHALL be 0 while rst is high.

Configuration
REQ-029 With WB_ARB_FIXED_PRIO_EN defined, req1 (FP) SHALL always win contention and last_grant is unused.
REQ-030 Without WB_ARB_FIXED_PRIO_EN, round-robin per REQ-016 applies.

Structure
REQ-031 Package wb_arb_pkg SHALL hold RD_W default, the entry struct typedef {data[31:0], rd, src}, and SRC_INT = 0 / SRC_FP = 1 constants.
REQ-032 The data select SHALL instantiate the team's existing mux_2X1_32bit component; no other sub-module.

Verification
REQ-033 Reset then idle -> wb_valid = 0, wb_data = 0, both readies 0 during rst.
REQ-034 Both valid every cycle (req0 data 0x1111_1111 rd 3, req1 0x2222_2222 rd 4), wb_ready = 1 -> grants alternate 0,1,0,1 starting with req0; wb_data alternates one cycle later.
REQ-035 wb_ready = 0 for 3 cycles with entry 0xDEAD_BEEF held -> output stable, readies 0; on wb_ready = 1 next entry loads the same cycle.
REQ-036 req1 valid with rd = 0, data 0xFFFF_FFFF -> req1_ready = 1, wb_valid stays 0, next contention grants req0.
REQ-037 rst asserted while FULL -> next cycle wb_valid = 0, wb_data = 0, and first contention after release grants req0.
REQ-038 Build with WB_ARB_FIXED_PRIO_EN, both valid for 4 cycles -> req1_ready high all 4 cycles, req0_ready low.
